// File: rtl/dist_tree_pkg.sv
// Shared geometry helpers for the distribution and reduction trees.
// Covers level count, nodes per level, leaf ranges and flat node offsets.
package dist_tree_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  function automatic int unsigned num_level(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Number of leaves owned by one node at level l
  function automatic int unsigned span_at_level(input int unsigned n, input int unsigned l);
    return 32'd1 << (num_level(n) - l);
  endfunction

  function automatic int unsigned nodes_at_level(input int unsigned n, input int unsigned l);
    return (n + span_at_level(n, l) - 32'd1) / span_at_level(n, l);
  endfunction

  function automatic int unsigned leaf_lo(input int unsigned n, input int unsigned l,
                                          input int unsigned j);
    return j * span_at_level(n, l);
  endfunction

  function automatic int unsigned leaf_hi(input int unsigned n, input int unsigned l,
                                          input int unsigned j);
    int unsigned top;
    top = (j + 32'd1) * span_at_level(n, l);
    return ((top < n) ? top : n) - 32'd1;
  endfunction

  // Index of the first node of level l when all levels are packed back to back
  function automatic int unsigned node_base(input int unsigned n, input int unsigned l);
    int unsigned sum;
    sum = 32'd0;
    for (int unsigned i = 0; i < l; i++) sum += nodes_at_level(n, i);
    return sum;
  endfunction

endpackage

// File: rtl/dist_tree_node.sv
// One registered parent-to-children hop: copies parent data to each child whose
// mask slice is non-zero; HAS_C1 = 0 builds the single-child tail variant.
module dist_tree_node
  import dist_tree_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned C0W        = 1,
  parameter int unsigned C1W        = 1,
  parameter int unsigned HAS_C1     = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          en,
  input  logic                                          p_valid,
  input  logic [DATA_WIDTH-1:0]                         p_data,
  input  logic [((HAS_C1 != 0) ? C0W + C1W : C0W)-1:0]  p_mask,
  output logic [((HAS_C1 != 0) ? 2 : 1)-1:0]            c_valid,
  output logic [((HAS_C1 != 0) ? 2 : 1)*DATA_WIDTH-1:0] c_data,
  output logic [((HAS_C1 != 0) ? C0W + C1W : C0W)-1:0]  c_mask
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned NC = (HAS_C1 != 0) ? 2 : 1;
  localparam int unsigned PW = (HAS_C1 != 0) ? C0W + C1W : C0W;

  logic [NC-1:0] load_c;
  logic [PW-1:0] keep_c;

  assign load_c[0]         = p_valid & en & (|p_mask[C0W-1:0]);
  assign keep_c[C0W-1:0]   = load_c[0] ? p_mask[C0W-1:0] : '0;

  if (HAS_C1 != 0) begin : g_c1
    assign load_c[1]        = p_valid & en & (|p_mask[PW-1:C0W]);
    assign keep_c[PW-1:C0W] = load_c[1] ? p_mask[PW-1:C0W] : '0;
  end

  // Children that are not selected load zeros, which also flushes on en = 0
  always_ff @(posedge clk) begin
    if (rst_n) begin
      c_valid <= '0;
      c_data  <= '0;
      c_mask  <= '0;
    end else begin
      c_valid <= load_c;
      c_mask  <= keep_c;
      for (int c = 0; c < NC; c++) c_data[c*W +: W] <= load_c[c] ? p_data : '0;
    end
  end

endmodule

// File: rtl/dist_tree_seq.sv
// Pipelined mask-directed distribution tree, one registered level per tree level.
// Define DIST_TREE_DROP_CNT_EN to add the saturating o_drop_cnt counter of zero-mask words.
module dist_tree_seq
  import dist_tree_pkg::*;
#(
  parameter int unsigned NUM_OUTPUT_DATA = 16,
  parameter int unsigned DATA_WIDTH      = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_valid,
  input  logic [DATA_WIDTH-1:0]                 i_data_bus,
  input  logic [NUM_OUTPUT_DATA-1:0]            i_dest_mask,
  input  logic                                  i_en,
  output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus
`ifdef DIST_TREE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]                 o_drop_cnt
`endif
);

  localparam int unsigned N         = NUM_OUTPUT_DATA;
  localparam int unsigned W         = DATA_WIDTH;
  localparam int unsigned NUM_LEVEL = num_level(N);
  localparam int unsigned TOTAL     = node_base(N, NUM_LEVEL + 1);
  localparam int unsigned LEAF_BASE = node_base(N, NUM_LEVEL);

  // All levels packed flat; each level's masks together cover exactly N leaf bits
  logic [TOTAL-1:0]           node_v;
  logic [TOTAL*W-1:0]         node_d;
  logic [(NUM_LEVEL+1)*N-1:0] node_m;

  assign node_v[0]     = i_valid;
  assign node_d[W-1:0] = i_data_bus;
  assign node_m[N-1:0] = i_dest_mask;

  for (genvar l = 1; l <= NUM_LEVEL; l++) begin : g_lvl
    for (genvar j = 0; j < nodes_at_level(N, l - 1); j++) begin : g_node
      localparam int unsigned PIDX   = node_base(N, l - 1) + j;
      localparam int unsigned CIDX   = node_base(N, l) + 2 * j;
      localparam int unsigned PLO    = leaf_lo(N, l - 1, j);
      localparam int unsigned PW     = leaf_hi(N, l - 1, j) - PLO + 1;
      localparam int unsigned C0W    = leaf_hi(N, l, 2 * j) - leaf_lo(N, l, 2 * j) + 1;
      localparam int unsigned HAS_C1 = (2 * j + 1 < nodes_at_level(N, l)) ? 1 : 0;
      localparam int unsigned NC     = (HAS_C1 != 0) ? 2 : 1;
      localparam int unsigned C1W    = (HAS_C1 != 0) ? PW - C0W : 1;

      dist_tree_node #(
        .DATA_WIDTH(W),
        .C0W       (C0W),
        .C1W       (C1W),
        .HAS_C1    (HAS_C1)
      ) u_node (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (i_en),
        .p_valid(node_v[PIDX]),
        .p_data (node_d[PIDX*W +: W]),
        .p_mask (node_m[(l-1)*N + PLO +: PW]),
        .c_valid(node_v[CIDX +: NC]),
        .c_data (node_d[CIDX*W +: NC*W]),
        .c_mask (node_m[l*N + PLO +: PW])
      );
    end
  end

  // A loaded leaf always has its own mask bit set, so the AND is the leaf valid
  assign o_valid    = node_v[LEAF_BASE +: N] & node_m[NUM_LEVEL*N +: N];
  assign o_data_bus = node_d[LEAF_BASE*W +: N*W];

`ifdef DIST_TREE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      o_drop_cnt <= '0;
    end else if (i_valid && i_en && (i_dest_mask == '0) && (o_drop_cnt != '1)) begin
      o_drop_cnt <= o_drop_cnt + DROP_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dist_tree_seq.sv
// Self-checking bench for dist_tree_seq: directed vector table, an N=5 tail case,
// and a randomized run against a history-based reference model.
module tb_dist_tree_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned NA = 16;
  localparam int unsigned NB = 5;
  localparam int LA = 4;
  localparam int LB = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic i_valid;
  logic i_en;
  logic [W-1:0]    i_data;
  logic [NA-1:0]   mask_a;
  logic [NB-1:0]   mask_b;
  logic [NA-1:0]   ov_a;
  logic [NA*W-1:0] od_a;
  logic [NB-1:0]   ov_b;
  logic [NB*W-1:0] od_b;
`ifdef DIST_TREE_DROP_CNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  always #5 clk = ~clk;

  dist_tree_seq #(.NUM_OUTPUT_DATA(NA), .DATA_WIDTH(W)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data_bus(i_data),
    .i_dest_mask(mask_a), .i_en(i_en), .o_valid(ov_a), .o_data_bus(od_a)
`ifdef DIST_TREE_DROP_CNT_EN
    , .o_drop_cnt(cnt_a)
`endif
  );

  dist_tree_seq #(.NUM_OUTPUT_DATA(NB), .DATA_WIDTH(W)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data_bus(i_data),
    .i_dest_mask(mask_b), .i_en(i_en), .o_valid(ov_b), .o_data_bus(od_b)
`ifdef DIST_TREE_DROP_CNT_EN
    , .o_drop_cnt(cnt_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic v, input logic [7:0] d,
                       input logic [15:0] ma, input logic [4:0] mb);
    rst_n   = rst;
    i_en    = en;
    i_valid = v;
    i_data  = d;
    mask_a  = ma;
    mask_b  = mb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic         en;
    logic         v;
    logic [7:0]   d;
    logic [15:0]  m;
    logic [15:0]  ev;
    logic [127:0] ed;
    logic [15:0]  ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic en, input logic v, input logic [7:0] d,
                     input logic [15:0] m, input logic [15:0] ev, input logic [127:0] ed,
                     input logic [15:0] ecnt);
    tbl.push_back('{rst, en, v, d, m, ev, ed, ecnt});
  endtask

  // Reference history for the random phase, one entry per clock edge
  logic        h_rst[$];
  logic        h_en[$];
  logic        h_v[$];
  logic [7:0]  h_d[$];
  logic [15:0] h_ma[$];
  logic [4:0]  h_mb[$];

  // A word sampled at edge s reaches the leaves after edge s+L-1 unless flushed
  function automatic logic word_ok(input int t, input int l);
    int s;
    s = t - l + 1;
    if (s < 0) return 1'b0;
    for (int e = s; e <= t; e++) if (h_rst[e] || !h_en[e]) return 1'b0;
    return h_v[s];
  endfunction

  function automatic logic [127:0] exp_bus(input logic ok, input logic [7:0] d,
                                           input logic [15:0] m, input int n);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < n; k++) if (ok && m[k]) r[k*8 +: 8] = d;
    return r;
  endfunction

  initial begin
    int s;
    logic ok;
    logic [15:0] ev16;
    logic [4:0]  ev5;
    int mcnt_a;
    int mcnt_b;

    drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 5'h00);

    // cycle-by-cycle directed vectors for the 16-leaf tree
    add(1, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd0);
    add(0, 1, 1, 8'hA5, 16'hFFFF, 16'h0000, '0, 16'd0);
    add(0, 1, 1, 8'h01, 16'h0001, 16'h0000, '0, 16'd0);
    add(0, 1, 1, 8'h02, 16'h8000, 16'h0000, '0, 16'd0);
    add(0, 1, 1, 8'h03, 16'h00F0, 16'hFFFF, {16{8'hA5}}, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0001, 128'h01, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h8000, {8'h02, 120'h0}, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h00F0, 128'h0303_0303_0000_0000, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd0);
    add(0, 1, 1, 8'h77, 16'h0000, 16'h0000, '0, 16'd1);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd1);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd1);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd1);
    add(0, 1, 1, 8'h11, 16'hFFFF, 16'h0000, '0, 16'd1);
    add(0, 1, 1, 8'h22, 16'h000F, 16'h0000, '0, 16'd1);
    add(0, 1, 1, 8'h33, 16'hF000, 16'h0000, '0, 16'd1);
    add(0, 0, 1, 8'h44, 16'hFFFF, 16'h0000, '0, 16'd1);
    add(0, 1, 1, 8'h55, 16'h0F0F, 16'h0000, '0, 16'd1);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd1);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd1);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0F0F, 128'h00000000_55555555_00000000_55555555, 16'd1);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd1);
    add(0, 1, 1, 8'hAA, 16'hFFFF, 16'h0000, '0, 16'd1);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd1);
    add(1, 1, 1, 8'h99, 16'hFFFF, 16'h0000, '0, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd0);
    add(0, 1, 1, 8'h5A, 16'h0100, 16'h0000, '0, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0100, {56'h0, 8'h5A, 64'h0}, 16'd0);
    add(0, 1, 0, 8'h00, 16'h0000, 16'h0000, '0, 16'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].m, 5'h00);
      tick();
      chk($sformatf("tbl%0d o_valid", i), 128'(ov_a), 128'(tbl[i].ev));
      chk($sformatf("tbl%0d o_data_bus", i), od_a, tbl[i].ed);
`ifdef DIST_TREE_DROP_CNT_EN
      chk($sformatf("tbl%0d o_drop_cnt", i), 128'(cnt_a), 128'(tbl[i].ecnt));
`endif
    end

    // Five-leaf tree: tail child at every level, latency of three
    drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 5'h00);
    tick();
    drive(1'b0, 1'b1, 1'b1, 8'h3C, 16'h0000, 5'b10001);
    tick();
    chk("n5 cycle1 o_valid", 128'(ov_b), 128'(0));
    drive(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 5'h00);
    tick();
    chk("n5 cycle2 o_valid", 128'(ov_b), 128'(0));
    tick();
    chk("n5 cycle3 o_valid", 128'(ov_b), 128'(5'b10001));
    chk("n5 cycle3 o_data_bus", 128'(od_b), 128'(40'h3C_0000_003C));
    tick();
    chk("n5 cycle4 o_valid", 128'(ov_b), 128'(0));

    // Randomized traffic against the history model; edge 0 is a reset
    mcnt_a = 0;
    mcnt_b = 0;
    for (int t = 0; t < 400; t++) begin
      logic r, e, v;
      logic [7:0]  d;
      logic [15:0] ma;
      logic [4:0]  mb;
      r  = (t == 0) || ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      ma = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      mb = ($urandom_range(0, 5) == 0) ? 5'h0 : 5'($urandom);
      h_rst.push_back(r);
      h_en.push_back(e);
      h_v.push_back(v);
      h_d.push_back(d);
      h_ma.push_back(ma);
      h_mb.push_back(mb);
      if (r) begin
        mcnt_a = 0;
        mcnt_b = 0;
      end else begin
        if (v && e && ma == 16'h0 && mcnt_a < 65535) mcnt_a++;
        if (v && e && mb == 5'h0 && mcnt_b < 65535) mcnt_b++;
      end
      drive(r, e, v, d, ma, mb);
      tick();

      ok   = word_ok(t, LA);
      s    = t - LA + 1;
      ev16 = ok ? h_ma[s] : 16'h0;
      chk($sformatf("rnd%0d a o_valid", t), 128'(ov_a), 128'(ev16));
      chk($sformatf("rnd%0d a o_data_bus", t), od_a,
          exp_bus(ok, ok ? h_d[s] : 8'h0, ev16, NA));

      ok  = word_ok(t, LB);
      s   = t - LB + 1;
      ev5 = ok ? h_mb[s] : 5'h0;
      chk($sformatf("rnd%0d b o_valid", t), 128'(ov_b), 128'(ev5));
      chk($sformatf("rnd%0d b o_data_bus", t), 128'(od_b),
          exp_bus(ok, ok ? h_d[s] : 8'h0, 16'(ev5), NB));
`ifdef DIST_TREE_DROP_CNT_EN
      chk($sformatf("rnd%0d a o_drop_cnt", t), 128'(cnt_a), 128'(mcnt_a));
      chk($sformatf("rnd%0d b o_drop_cnt", t), 128'(cnt_b), 128'(mcnt_b));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dist_tree_seq.md
DIST_TREE_SEQ -- requirements
Module: dist_tree_seq

Interface
REQ-001 NUM_OUTPUT_DATA, default 16, meaning number of leaf outputs, any integer >= 1.
REQ-002 DATA_WIDTH, default 8, meaning width of one data word.
REQ-003 clk  input  1  meaning single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  meaning reset, synchronous and active-high (asserted = 1 clears state on the clk edge).
REQ-005 i_valid  input  1  meaning input word present this cycle.
REQ-006 i_data_bus  input  DATA_WIDTH  meaning word to distribute.
REQ-007 i_dest_mask  input  NUM_OUTPUT_DATA  meaning bit k = 1 selects leaf k.
REQ-008 i_en  input  1  meaning distribute enable.
REQ-009 o_valid  output  NUM_OUTPUT_DATA  meaning per-leaf output valid.
REQ-010 o_data_bus  output  NUM_OUTPUT_DATA*DATA_WIDTH  meaning leaf k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-011 NUM_LEVEL SHALL be $clog2(NUM_OUTPUT_DATA), forced to 1 when NUM_OUTPUT_DATA = 1.
REQ-012 Level l (0..NUM_LEVEL) SHALL hold ceil(NUM_OUTPUT_DATA / 2^(NUM_LEVEL-l)) nodes; level 0 = root (combinational from inputs), levels 1..NUM_LEVEL registered.
REQ-013 Node j at level l SHALL own leaf range [j*2^(NUM_LEVEL-l), min((j+1)*2^(NUM_LEVEL-l), NUM_OUTPUT_DATA)-1] and carry data plus the mask slice for that range.
REQ-014 Node j at level l SHALL feed children 2j and 2j+1 at level l+1; a missing child (non-power-of-2 tail) SHALL be omitted, not padded.
REQ-015 A child register SHALL load valid=1, parent data and its own mask slice when parent valid=1, i_en=1 and its mask slice is non-zero; otherwise valid=0, data=0, mask=0.
REQ-016 Latency SHALL be exactly NUM_LEVEL cycles from i_valid sample to o_valid; throughput one word per cycle, no backpressure.
REQ-017 o_valid[k] SHALL equal leaf-register valid; o_data_bus slice k SHALL be 0 when o_valid[k] = 0.
REQ-018 i_valid=1 with i_dest_mask=0 SHALL be dropped at level 1: no output on any leaf.
REQ-019 i_en=0 SHALL load every register with zeros on that edge (full pipeline flush); in-flight words are lost.
REQ-020 Consecutive words with disjoint or overlapping masks SHALL not interfere; each appears on its own masked leaves in its own cycle.

Reset
REQ-021 rst_n=1 at a clk edge SHALL clear all node valid, data and mask registers; o_valid=0, o_data_bus=0 from the next cycle.
REQ-022 Reset mid-operation SHALL discard all in-flight words; inputs sampled while rst_n=1 SHALL be ignored.
REQ-023 First word accepted after rst_n deasserts SHALL appear NUM_LEVEL cycles later.

Configuration
REQ-024 Macro DIST_TREE_DROP_CNT_EN defined: output o_drop_cnt (16 bits) SHALL count words with i_valid=1, i_en=1, i_dest_mask=0, saturating at 16'hFFFF, cleared by reset.
REQ-025 DIST_TREE_DROP_CNT_EN undefined: o_drop_cnt port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-026 Package dist_tree_pkg SHALL hold functions for level count, nodes per level and leaf-range bounds, shared with the reduction trees.
REQ-027 One sub-module dist_tree_node (registered one-to-two fan-out with mask slicing, single-child mode for tail) SHALL be instantiated per non-root node pair.

Verification
REQ-028 N=16, W=8: i_valid=1, data=8'hA5, mask=16'hFFFF -> after 4 cycles o_valid=16'hFFFF, every slice 8'hA5, one cycle only.
REQ-029 N=16: back-to-back data 8'h01 mask 16'h0001, 8'h02 mask 16'h8000, 8'h03 mask 16'h00F0 -> cycles 4,5,6 show leaf0=01, leaf15=02, leaves4-7=03, all other slices 0.
REQ-030 N=16: mask=0, valid=1 -> no o_valid ever; with DIST_TREE_DROP_CNT_EN o_drop_cnt increments by 1.
REQ-031 N=16: three words in flight, i_en=0 for one cycle -> all in-flight words absent at outputs; word sent after i_en=1 arrives 4 cycles later.
REQ-032 N=5 (NUM_LEVEL=3): mask=5'b10001, data 8'h3C -> after 3 cycles o_valid=5'b10001, leaves 0 and 4 = 8'h3C.
REQ-033 Reset asserted 2 cycles after a broadcast -> o_valid stays 0; counter (if built) reads 0.
